// File: rtl/reconfig_multi_seq_if.sv
// Sample-side, result-side and coefficient-configuration signals of reconfig_multi_seq.
// master = source/consumer/configurator; slave = the multiplier.
interface reconfig_multi_seq_if #(
  parameter int W      = 32,
  parameter int COEF_W = 8,
  parameter int MODE_W = 2
);
  logic [W-1:0]      x;
  logic [MODE_W-1:0] mode;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      y;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [MODE_W-1:0] cfg_addr;
  logic [COEF_W-1:0] cfg_data;

  modport master (
    output x, mode, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, y, ovf, out_valid
  );

  modport slave (
    input  x, mode, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, y, ovf, out_valid
  );
endinterface

// File: rtl/reconfig_multi_seq.sv
// Sequential shift-add multiplier: y = x * coef[mode], one coefficient bit per cycle,
// with a runtime-writable coefficient table and valid/ready on both sides.
module reconfig_multi_seq #(
  parameter int W      = 32,
  parameter int COEF_W = 8,
  parameter int MODE_W = 2
) (
  input logic                clk,
  input logic                rst_n,
  reconfig_multi_seq_if.slave bus
);

  localparam int ACC_W   = W + COEF_W;
  localparam int N_MODES = 2 ** MODE_W;
  localparam int CNT_W   = $clog2(COEF_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [COEF_W-1:0] coef [N_MODES];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  xs;
  logic [COEF_W-1:0] cs;
  logic [CNT_W-1:0]  cnt;
  logic [W-1:0]      y_q;
  logic              ovf_q;
  logic              cnt_done;

  assign cnt_done = (cnt == CNT_W'(COEF_W));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt_done) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_MODES; k++) coef[k] <= COEF_W'(k + 1);
    end else if (bus.cfg_we) begin
      coef[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // x is pre-shifted and the latched coefficient shifted right, so bit 0 of cs and
  // xs stand in for coef[cnt] and x<<cnt; the final BUSY cycle publishes the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      xs    <= '0;
      cs    <= '0;
      cnt   <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xs  <= ACC_W'(bus.x);
            cs  <= coef[bus.mode];
            acc <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          if (!cnt_done) begin
            if (cs[0]) acc <= acc + xs;
            xs  <= xs << 1;
            cs  <= cs >> 1;
            cnt <= cnt + CNT_W'(1);
          end else begin
            y_q   <= acc[W-1:0];
            ovf_q <= |acc[ACC_W-1:W];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.y   = y_q;
  assign bus.ovf = ovf_q;

endmodule
